// File: rtl/elevator_ctrl.sv
// Single-car collective (SCAN) elevator controller: latches hall/cabin calls, sweeps in one
// direction while calls remain ahead, and times floor-to-floor travel and door dwell in cycles.
module elevator_ctrl #(
  parameter int FLOORS     = 8,
  parameter int FW         = 3,
  parameter int TRAVEL_CYC = 16,
  parameter int DOOR_CYC   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] hall_req,
  input  logic [FLOORS-1:0] car_req,
  output logic [FW-1:0]     floor_o,
  output logic [1:0]        dir_o,
  output logic              moving_o,
  output logic              door_open_o,
  output logic              busy_o,
  output logic [FLOORS-1:0] pending_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_MOVE  = 2'b01;
  localparam logic [1:0] ST_DOOR  = 2'b10;
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  localparam int TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] T_TRAVEL_END = TW'(TRAVEL_CYC - 1);
  localparam logic [TW-1:0] T_DOOR_END   = TW'(DOOR_CYC - 1);
  localparam logic [FW-1:0] TOP_FLOOR    = FW'(FLOORS - 1);

  function automatic logic calls_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) r = r | (p[i] & (i > int'(f)));
    return r;
  endfunction

  function automatic logic calls_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) r = r | (p[i] & (i < int'(f)));
    return r;
  endfunction

  function automatic logic call_at(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) r = r | (p[i] & (i == int'(f)));
    return r;
  endfunction

  function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [FLOORS-1:0] r;
    for (int i = 0; i < FLOORS; i++) r[i] = (i == int'(f));
    return r;
  endfunction

  // Keep sweeping the current way while calls remain ahead; a stopped car prefers up.
  function automatic logic [1:0] pick_dir(input logic [1:0] d, input logic ab, input logic be);
    logic [1:0] r;
    case (d)
      DIR_DN:  r = be ? DIR_DN : (ab ? DIR_UP : DIR_NONE);
      DIR_UP:  r = ab ? DIR_UP : (be ? DIR_DN : DIR_NONE);
      default: r = ab ? DIR_UP : (be ? DIR_DN : DIR_NONE);
    endcase
    return r;
  endfunction

  logic [1:0]        state_r, state_s;
  logic [FW-1:0]     floor_r, floor_s, nf_s;
  logic [1:0]        dir_r, dir_s, pick_s;
  logic [TW-1:0]     timer_r, timer_s;
  logic [FLOORS-1:0] pending_r, pend_s, req_s, clr_s;
  logic              moving_r, door_r, busy_r;

  // Next-state decisions, all taken on pend_s so a call is seen at the edge it arrives.
  always_comb begin
    req_s   = hall_req | car_req;
    pend_s  = pending_r | req_s;
    state_s = state_r;
    floor_s = floor_r;
    dir_s   = dir_r;
    timer_s = timer_r;
    clr_s   = '0;
    nf_s    = floor_r;
    pick_s  = DIR_NONE;
    case (state_r)
      ST_IDLE: begin
        timer_s = '0;
        if (call_at(pend_s, floor_r)) begin
          state_s = ST_DOOR;
          clr_s   = onehot(floor_r);
        end else begin
          pick_s  = pick_dir(DIR_NONE, calls_above(pend_s, floor_r), calls_below(pend_s, floor_r));
          dir_s   = pick_s;
          state_s = (pick_s == DIR_NONE) ? ST_IDLE : ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (timer_r != T_TRAVEL_END) begin
          timer_s = timer_r + TW'(1);
        end else begin
          timer_s = '0;
          if (dir_r == DIR_UP && floor_r != TOP_FLOOR) begin
            nf_s = floor_r + FW'(1);
          end else if (dir_r == DIR_DN && floor_r != '0) begin
            nf_s = floor_r - FW'(1);
          end else begin
            nf_s = floor_r;
          end
          floor_s = nf_s;
          if (call_at(pend_s, nf_s)) begin
            state_s = ST_DOOR;
            clr_s   = onehot(nf_s);
          end else begin
            pick_s  = pick_dir(dir_r, calls_above(pend_s, nf_s), calls_below(pend_s, nf_s));
            dir_s   = pick_s;
            state_s = (pick_s == DIR_NONE) ? ST_IDLE : ST_MOVE;
          end
        end
      end
      ST_DOOR: begin
        clr_s = onehot(floor_r);
        if (call_at(req_s, floor_r)) begin
          timer_s = '0;
        end else if (timer_r != T_DOOR_END) begin
          timer_s = timer_r + TW'(1);
        end else begin
          timer_s = '0;
          pick_s  = pick_dir(dir_r, calls_above(pend_s, floor_r), calls_below(pend_s, floor_r));
          dir_s   = pick_s;
          state_s = (pick_s == DIR_NONE) ? ST_IDLE : ST_MOVE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        dir_s   = DIR_NONE;
        timer_s = '0;
      end
    endcase
  end

  // State, position, call register and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      floor_r   <= '0;
      dir_r     <= DIR_NONE;
      timer_r   <= '0;
      pending_r <= '0;
      moving_r  <= 1'b0;
      door_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      floor_r   <= floor_s;
      dir_r     <= dir_s;
      timer_r   <= timer_s;
      pending_r <= pend_s & ~clr_s;
      moving_r  <= (state_s == ST_MOVE);
      door_r    <= (state_s == ST_DOOR);
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  assign floor_o     = floor_r;
  assign dir_o       = dir_r;
  assign moving_o    = moving_r;
  assign door_open_o = door_r;
  assign busy_o      = busy_r;
  assign pending_o   = pending_r;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl (FLOORS=8, TRAVEL_CYC=4, DOOR_CYC=3): cycle-exact vector table via a
// scoreboard queue, then hand sequences for stops en route, reversal, door restart and reset.
module tb_elevator_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] hall_req;
  logic [7:0] car_req;
  logic [2:0] floor_o;
  logic [1:0] dir_o;
  logic       moving_o;
  logic       door_open_o;
  logic       busy_o;
  logic [7:0] pending_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] hall;
    logic [7:0] car;
    logic [2:0] floor;
    logic [1:0] dir;
    logic       moving;
    logic       door;
    logic       busy;
    logic [7:0] pend;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;
  vec_t exp_q[$];

  elevator_ctrl #(.FLOORS(8), .FW(3), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n), .hall_req(hall_req), .car_req(car_req),
    .floor_o(floor_o), .dir_o(dir_o), .moving_o(moving_o), .door_open_o(door_open_o),
    .busy_o(busy_o), .pending_o(pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {16'd0, floor_o, dir_o, moving_o, door_open_o, busy_o, pending_o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(input logic [7:0] h, input logic [7:0] c);
    @(negedge clk);
    hall_req = h;
    car_req  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [7:0] h, input logic [7:0] c, input logic [2:0] f,
                         input logic [1:0] d, input logic m, input logic dr, input logic [7:0] p);
    vecs[nv].hall   = h;
    vecs[nv].car    = c;
    vecs[nv].floor  = f;
    vecs[nv].dir    = d;
    vecs[nv].moving = m;
    vecs[nv].door   = dr;
    vecs[nv].busy   = m | dr;
    vecs[nv].pend   = p;
    nv++;
  endtask

  task automatic wait_floor(input logic [2:0] f);
    int n = 0;
    while (floor_o !== f && n < 100) begin
      tick(8'h00, 8'h00);
      n++;
    end
    check("wait_floor", {29'd0, floor_o}, {29'd0, f});
  endtask

  task automatic wait_door();
    int n = 0;
    while (door_open_o !== 1'b1 && n < 200) begin
      tick(8'h00, 8'h00);
      n++;
    end
    check("wait_door", {31'd0, door_open_o}, 32'd1);
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (door_open_o === 1'b1 && n < 50) begin
      tick(8'h00, 8'h00);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hall_req = 8'h00;
    car_req  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t e;
    int   nd;
    rst_n    = 1'b0;
    hall_req = 8'h00;
    car_req  = 8'h00;

    // Hall call at the resting floor opens the door at once; then a 3-floor trip up.
    add_vec(8'h01, 8'h00, 3'd0, 2'b00, 1'b0, 1'b1, 8'h00);
    add_vec(8'h00, 8'h00, 3'd0, 2'b00, 1'b0, 1'b1, 8'h00);
    add_vec(8'h00, 8'h00, 3'd0, 2'b00, 1'b0, 1'b1, 8'h00);
    add_vec(8'h00, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 17; k++) begin
      if (k < 12)
        add_vec(8'h00, (k == 0) ? 8'h08 : 8'h00, 3'(k / 4), 2'b01, 1'b1, 1'b0, 8'h08);
      else if (k < 15)
        add_vec(8'h00, 8'h00, 3'd3, 2'b01, 1'b0, 1'b1, 8'h00);
      else
        add_vec(8'h00, 8'h00, 3'd3, 2'b00, 1'b0, 1'b0, 8'h00);
    end

    do_reset();

    for (int i = 0; i < nv; i++) begin
      exp_q.push_back(vecs[i]);
      tick(vecs[i].hall, vecs[i].car);
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), outs(),
            {16'd0, e.floor, e.dir, e.moving, e.door, e.busy, e.pend});
    end

    // Intermediate hall call picked up on the way from 0 to 6.
    do_reset();
    tick(8'h00, 8'h40);
    check("s3_start", {30'd0, dir_o}, 32'd1);
    wait_floor(3'd2);
    tick(8'h10, 8'h00);
    check("s3_pend", {24'd0, pending_o}, 32'h50);
    wait_door();
    check("s3_stop4", {29'd0, floor_o}, 32'd4);
    count_door(nd);
    check("s3_door4_len", nd, 32'd3);
    check("s3_resume", {30'd0, dir_o, moving_o}, {29'd0, 2'b01, 1'b1});
    wait_door();
    check("s3_stop6", {29'd0, floor_o}, 32'd6);
    count_door(nd);
    check("s3_idle", outs(), {16'd0, 3'd6, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00});

    // Park at 3, then calls on both sides: up first, then reverse.
    tick(8'h00, 8'h08);
    wait_door();
    check("s4_at3", {29'd0, floor_o}, 32'd3);
    count_door(nd);
    check("s4_idle3", {31'd0, busy_o}, 32'd0);
    tick(8'h00, 8'h42);
    check("s4_up", outs(), {16'd0, 3'd3, 2'b01, 1'b1, 1'b0, 1'b1, 8'h42});
    wait_door();
    check("s4_at6", {27'd0, floor_o, dir_o}, {27'd0, 3'd6, 2'b01});
    count_door(nd);
    check("s4_down", {30'd0, dir_o}, 32'd2);
    wait_door();
    check("s4_at1", {27'd0, floor_o, dir_o}, {27'd0, 3'd1, 2'b10});
    count_door(nd);
    check("s4_idle1", outs(), {16'd0, 3'd1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00});

    // Door restart: cabin button at the open floor pressed on two consecutive cycles.
    tick(8'h00, 8'h20);
    wait_door();
    check("s5_at5", {29'd0, floor_o}, 32'd5);
    tick(8'h00, 8'h20);
    check("s5_hold1", {23'd0, door_open_o, pending_o}, {23'd0, 1'b1, 8'h00});
    tick(8'h00, 8'h20);
    check("s5_hold2", {23'd0, door_open_o, pending_o}, {23'd0, 1'b1, 8'h00});
    count_door(nd);
    check("s5_door_len", nd, 32'd3);
    check("s5_idle", outs(), {16'd0, 3'd5, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00});

    // Asynchronous reset in the middle of the 2->3 hop.
    do_reset();
    tick(8'h00, 8'h88);
    wait_floor(3'd2);
    tick(8'h00, 8'h00);
    check("s6_moving", {23'd0, moving_o, pending_o}, {23'd0, 1'b1, 8'h88});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick(8'h00, 8'h00);
    check("s6_after", outs(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
